// File: rtl/cycle_sequencer_pkg.sv
// Shared definitions for the instruction-cycle sequencer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cycle_sequencer_pkg;

    // Bit positions of the one-hot machine state vector
    localparam int ST_HALT   = 0;
    localparam int ST_FETCH  = 1;
    localparam int ST_DECODE = 2;
    localparam int ST_LOAD   = 3;
    localparam int ST_EXEC   = 4;
    localparam int ST_STORE  = 5;
    localparam int NUM_ST    = 6;

    // One-hot codes matching the bit positions above
    localparam logic [NUM_ST-1:0] OH_HALT   = 6'b000001;
    localparam logic [NUM_ST-1:0] OH_FETCH  = 6'b000010;
    localparam logic [NUM_ST-1:0] OH_DECODE = 6'b000100;
    localparam logic [NUM_ST-1:0] OH_LOAD   = 6'b001000;
    localparam logic [NUM_ST-1:0] OH_EXEC   = 6'b010000;
    localparam logic [NUM_ST-1:0] OH_STORE  = 6'b100000;

    // Default build parameters
    localparam int DEF_PHASES = 2;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/cycle_sequencer_phase.sv
// Phase divider: counts PHASES clk periods per machine state and drives cdiv/ncdiv/last_phase.
// Latency: cdiv registered from the next phase value; last_phase decoded from the current phase.
// Backpressure: none; counting gated by en, hold synchronously parks the phase at 0.
module phase_divider #(
    parameter int PHASES = 2
) (
    input  logic clk,
    input  logic nreset,
    input  logic en,
    input  logic hold,
    output logic cdiv,
    output logic ncdiv,
    output logic last_phase
);

    localparam int PH_W = $clog2(PHASES);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(PHASES / 2);

    logic [PH_W-1:0] ph_q;
    logic [PH_W-1:0] ph_d;
    logic            cdiv_q;

    // Next phase: park at 0 while held, otherwise count and wrap at the last phase
    always_comb begin
        ph_d = ph_q;
        if (hold) begin
            ph_d = '0;
        end else if (en) begin
            ph_d = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
        end
    end

    // Phase register; cdiv is registered from the next phase so it is glitch-free
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ph_q   <= '0;
            cdiv_q <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            cdiv_q <= (ph_d >= PH_HALF);
        end
    end

    assign cdiv       = cdiv_q;
    assign ncdiv      = ~cdiv_q;
    assign last_phase = en && (ph_q == PH_LAST);

endmodule

// File: rtl/cycle_sequencer.sv
// Instruction-cycle sequencer: fetch/decode/load/execute/store with memory stalls, run/step/halt.
// Latency: state changes on the edge that wraps the phase; instr_done is same-cycle on the final phase.
// Backpressure: mem_ready low on a last phase repeats FETCH/LOAD/STORE for another full state.
module cycle_sequencer
    import cycle_sequencer_pkg::*;
#(
    parameter int PHASES = DEF_PHASES,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              run,
    input  logic              step,
    input  logic              halt_req,
    input  logic              need_load,
    input  logic              need_store,
    input  logic              mem_ready,
    output logic              cdiv,
    output logic              ncdiv,
    output logic [NUM_ST-1:0] state,
    output logic              last_phase,
    output logic              instr_done,
    output logic              stop_pulse,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    logic [NUM_ST-1:0] state_q;
    logic [NUM_ST-1:0] state_d;
    logic              step_mode_q;
    logic              step_mode_d;
    logic              eoi;
    logic              lp;
    logic              is_halt;
    logic              stop_q;
    logic [CNT_W-1:0]  cnt_q;

    assign is_halt = state_q[ST_HALT];

    phase_divider #(
        .PHASES(PHASES)
    ) u_phase (
        .clk        (clk),
        .nreset     (nreset),
        .en         (!is_halt),
        .hold       (is_halt),
        .cdiv       (cdiv),
        .ncdiv      (ncdiv),
        .last_phase (lp)
    );

    // State register and the single-step flag
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= OH_HALT;
            step_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_mode_q <= step_mode_d;
        end
    end

    // Next state: HALT reacts every clk, other states only on their last phase
    always_comb begin
        state_d     = state_q;
        step_mode_d = step_mode_q;
        eoi         = 1'b0;
        case (1'b1)
            state_q[ST_HALT]: begin
                if (run) begin
                    state_d     = OH_FETCH;
                    step_mode_d = 1'b0;
                end else if (step) begin
                    state_d     = OH_FETCH;
                    step_mode_d = 1'b1;
                end
            end
            state_q[ST_FETCH]: begin
                if (lp && mem_ready) state_d = OH_DECODE;
            end
            state_q[ST_DECODE]: begin
                if (lp) state_d = need_load ? OH_LOAD : OH_EXEC;
            end
            state_q[ST_LOAD]: begin
                if (lp && mem_ready) state_d = OH_EXEC;
            end
            state_q[ST_EXEC]: begin
                if (lp) begin
                    if (need_store) state_d = OH_STORE;
                    else            eoi     = 1'b1;
                end
            end
            state_q[ST_STORE]: begin
                if (lp && mem_ready) eoi = 1'b1;
            end
            default: begin
                // Not one-hot: fall back to a safe stop
                state_d     = OH_HALT;
                step_mode_d = 1'b0;
            end
        endcase
        // Instruction boundary: halt request beats single-step beats run level
        if (eoi) begin
            if (halt_req || step_mode_q || !run) begin
                state_d     = OH_HALT;
                step_mode_d = 1'b0;
            end else begin
                state_d = OH_FETCH;
            end
        end
    end

    // Outputs decoded from the current state and boundary condition
    always_comb begin
        state       = state_q;
        halted      = is_halt;
        last_phase  = lp;
        instr_done  = eoi;
        stop_pulse  = stop_q;
        instr_count = cnt_q;
    end

    // Stop pulse marks the first clk in HALT after a running state; counter tracks completions
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            stop_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            stop_q <= state_d[ST_HALT] && !is_halt;
            if (eoi) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
- Instruction-cycle sequencer that sits directly downstream of the free-running clock generator and consumes `clk`.
- Splits each machine state into PHASES clock periods and produces the `cdiv`/`ncdiv` pair that the clock block uses to gate its `ws` and `sc` strobes.
- Steps the CPU through fetch/decode/load/execute/store with memory-ready stalls.
- Handles run, single-step and halt, and reports stop events back to the start/stop latch logic.

Parameters:
- PHASES, 2, clk periods per machine state; must be even and >= 2.
- CNT_W, 16, width of the completed-instruction counter.

Ports:
- clk  input  1  system clock from the clock generator; all state changes on its rising edge.
- nreset  input  1  asynchronous, active-low reset.
- run  input  1  level; 1 = free-run, 0 = stop at the next instruction boundary.
- step  input  1  one-clk pulse; executes one instruction from HALT.
- halt_req  input  1  level from the decoder (HLT instruction); honoured at the instruction boundary.
- need_load  input  1  decoder: the current instruction reads memory.
- need_store  input  1  decoder: the current instruction writes memory.
- mem_ready  input  1  memory access complete; sampled on the last phase only.
- cdiv  output  1  high for the second half of the phases in each state.
- ncdiv  output  1  always the complement of `cdiv`.
- state  output  6  one-hot: {STORE, EXEC, LOAD, DECODE, FETCH, HALT}.
- last_phase  output  1  high during the final phase of the current state.
- instr_done  output  1  one-clk pulse on the final phase of an instruction's last state.
- stop_pulse  output  1  one-clk pulse when the sequencer enters HALT from a running state.
- halted  output  1  equals state == HALT.
- instr_count  output  CNT_W  number of completed instructions; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, any time, including mid-instruction):
  - state = HALT, phase = 0, cdiv = 0, ncdiv = 1, halted = 1.
  - last_phase = 0, instr_done = 0, stop_pulse = 0, instr_count = 0, step_mode = 0.
- Phase counter:
  - ph counts 0..PHASES-1 and wraps to 0. It advances every clk when state != HALT.
  - In HALT, ph is held at 0.
  - cdiv = (ph >= PHASES/2); it is registered, so there are no glitches.
  - last_phase = (ph == PHASES-1) && !HALT.
- State transitions are evaluated only when last_phase = 1. The next state takes effect on the same edge where ph wraps to 0.
  - HALT (evaluated every clk, not phase-gated):
    - run = 1 → FETCH, step_mode = 0.
    - else step = 1 → FETCH, step_mode = 1.
    - run and step both high → run wins.
  - FETCH: mem_ready → DECODE; otherwise repeat FETCH (ph wraps, cdiv keeps toggling).
  - DECODE: need_load → LOAD, otherwise EXEC.
  - LOAD: mem_ready → EXEC; otherwise repeat LOAD.
  - EXEC: need_store → STORE; otherwise end-of-instruction.
  - STORE: mem_ready → end-of-instruction; otherwise repeat STORE.
  - need_load and need_store are sampled only at the DECODE and EXEC boundaries respectively.
- End-of-instruction, on the final last_phase of the instruction:
  - instr_done = 1 for that clk; instr_count increments on the same edge.
  - If halt_req, or step_mode, or run = 0: go to HALT, with stop_pulse = 1 for one clk on the entry edge and step_mode cleared.
  - Otherwise go to FETCH.
  - Priority: halt_req > step_mode > run.
- Deassertion of run mid-instruction does not abort; the instruction completes.
- A step pulse outside HALT is ignored.
- Minimum instruction length: 3 states × PHASES clks (FETCH, DECODE, EXEC) with mem_ready held high.

Decomposition:
- Shared package holds:
  - State index constants ST_HALT..ST_STORE (one-hot bit positions).
  - Default PHASES and CNT_W.
- One natural sub-module, `phase_divider`: the ph counter plus the cdiv/ncdiv/last_phase generation, with an enable input (!HALT) and a synchronous hold-at-0. The FSM and the counters live in the top module.

Test Plan:
- Reset mid-EXEC with PHASES=2 → immediately state=000001, cdiv=0, ncdiv=1, instr_count=0, no stop_pulse.
- run=1, mem_ready=1, need_load=need_store=0:
  - Sequence FETCH, DECODE, EXEC repeats.
  - instr_done every 6 clks; instr_count reaches 5 after 30 clks.
  - cdiv toggles every clk.
- need_load=1, need_store=1, mem_ready low for 2 last_phase samples in LOAD:
  - Path FETCH, DECODE, LOAD×3, EXEC, STORE.
  - Instruction takes 14 clks at PHASES=2.
- From HALT, pulse step once with run=0 → exactly one instruction completes, then HALT; stop_pulse=1 for one clk; instr_count +1. A second step pulse during that instruction is ignored.
- run=1 with halt_req asserted during EXEC → HALT after EXEC's last phase, stop_pulse high. Repeat with run and step both high in HALT: step_mode=0 and execution continues.
- CNT_W=4: run 16 instructions → instr_count wraps 15→0. PHASES=4: cdiv low for 2 clks, then high for 2 clks, in each state.
